collision_monitor: RTL and testbench
====================================

COLLISION_MONITOR -- requirements
Module: collision_monitor

Interface
REQ-001 The module SHALL have parameter LIVES_INIT, default 3: lives loaded at reset and restart (1..3).
REQ-002 The module SHALL have parameter GOAL_Y, default 9'd20: frog top edge at or above this row means goal reached.
REQ-003 The module SHALL have parameter INVULN_FRAMES, default 8'd60: frames of hit immunity after a hit.
REQ-004 clk_in  input  1  system clock; one clock only.
REQ-005 reset_in  input  1  asynchronous, active-low reset.
REQ-006 frame_tick  input  1  one-cycle pulse per frame; all evaluation happens only on cycles where it is high.
REQ-007 start  input  1  restart request, honoured only in OVER.
REQ-008 carL, carR  input  10  car box horizontal edges, consumed exactly as the car block drives them.
REQ-009 carT, carB  input  9  car box vertical edges.
REQ-010 frogL, frogR  input  10; frogT, frogB  input  9  frog box edges.
REQ-011 pseudo  output  1  car enable; 0 holds cars at spawn.
REQ-012 level  output  3  current level, fed to the car block.
REQ-013 lives  output  2  remaining lives.
REQ-014 hit_pulse, frog_respawn, game_over  output  1 each  registered status outputs.

Function
REQ-015 Overlap SHALL be strict: frogL<carR and frogR>carL and frogT<carB and frogB>carT; shared edges are not overlap.
REQ-016 The overlap result SHALL be registered into ov_prev on every frame_tick; a hit requires overlap on two consecutive frame_ticks (current and ov_prev).
REQ-017 States SHALL be PLAY, HIT, OVER.
REQ-018 PLAY, frame_tick, hit condition, lives>1: lives decrements, hit_pulse and frog_respawn pulse for one cycle, invulnerability counter loads INVULN_FRAMES, next state HIT.
REQ-019 PLAY, frame_tick, hit condition, lives==1: lives becomes 0, hit_pulse pulses, next state OVER.
REQ-020 PLAY, frame_tick, frogT<=GOAL_Y, no hit condition: level increments, saturating at 7; frog_respawn pulses; ov_prev clears; state stays PLAY.
REQ-021 Hit and goal on the same frame_tick: the hit SHALL win and level SHALL be unchanged.
REQ-022 HIT: the counter decrements on each frame_tick and overlap is ignored; on the frame_tick where the counter is 1, state goes to PLAY and ov_prev clears.
REQ-023 OVER: game_over=1 and pseudo=0, and all frame inputs are ignored.
REQ-024 OVER: start=1 reloads lives=LIVES_INIT and level=0, clears ov_prev, pulses frog_respawn, and enters PLAY the next cycle.
REQ-025 pseudo SHALL be 1 in PLAY and HIT.
REQ-026 All outputs SHALL be registered.
REQ-027 hit_pulse and frog_respawn SHALL be high for exactly one clk_in cycle per event.
REQ-028 Without frame_tick, no state, counter, lives or level change SHALL occur, except start in OVER.

Reset
REQ-029 reset_in low SHALL immediately force: state PLAY, lives=LIVES_INIT, level=0, pseudo=1, hit_pulse=0, frog_respawn=0, game_over=0, counter=0, ov_prev=0.
REQ-030 Reset asserted mid-HIT or mid-OVER SHALL abandon that state with no residual pulse after release.

Structure
REQ-031 Package frogger_pkg SHALL hold the state encoding (PLAY/HIT/OVER), the screen-width constants (10-bit x, 9-bit y) and the default parameter values.
REQ-032 Sub-module box_overlap SHALL be the purely combinational strict-overlap test, instantiated once.

Verification
REQ-033 Car 20/80/110/150, frog 40/60/120/140 on two consecutive ticks -> hit_pulse on the second tick, lives 3->2, state HIT.
REQ-034 Same overlap on one tick only, then frog 200/220 -> no hit, lives stay 3.
REQ-035 Frog R=20 vs car L=20 (edge touch) for 5 ticks -> no hit.
REQ-036 Three separated hits with INVULN_FRAMES=4 -> lives 3,2,1,0; game_over=1 and pseudo=0; start -> lives=3, level=0, PLAY.
REQ-037 frogT=20 with no overlap, repeated 9 times -> level saturates at 7; one frog_respawn per tick.
REQ-038 Goal and second overlap tick on the same frame_tick -> hit taken, level unchanged; reset_in pulsed low mid-HIT -> all outputs at reset values immediately.

Source files
------------

// File: rtl/frogger_pkg.sv
// Shared Frogger definitions: game state encoding, screen coordinate widths
// and the default tuning values for the collision monitor.
package frogger_pkg;

  typedef enum logic [1:0] {
    PLAY = 2'd0,
    HIT  = 2'd1,
    OVER = 2'd2
  } state_t;

  localparam int X_W = 10;
  localparam int Y_W = 9;

  localparam int             LIVES_INIT_DEF    = 3;
  localparam logic [Y_W-1:0] GOAL_Y_DEF        = 9'd20;
  localparam logic [7:0]     INVULN_FRAMES_DEF = 8'd60;
  localparam logic [2:0]     LEVEL_MAX         = 3'd7;

endpackage

// File: rtl/box_overlap.sv
// Strict axis-aligned box intersection between the car and the frog;
// boxes that merely share an edge do not overlap.
module box_overlap
  import frogger_pkg::*;
(
  input  logic [X_W-1:0] carL,
  input  logic [X_W-1:0] carR,
  input  logic [Y_W-1:0] carT,
  input  logic [Y_W-1:0] carB,
  input  logic [X_W-1:0] frogL,
  input  logic [X_W-1:0] frogR,
  input  logic [Y_W-1:0] frogT,
  input  logic [Y_W-1:0] frogB,
  output logic           overlap
);

  assign overlap = (frogL < carR) && (frogR > carL) &&
                   (frogT < carB) && (frogB > carT);

endmodule

// File: rtl/collision_monitor.sv
// Game-rule engine: turns per-frame car/frog overlap into hits, lives,
// level progression, invulnerability and game-over handling.
module collision_monitor
  import frogger_pkg::*;
#(
  parameter int             LIVES_INIT    = LIVES_INIT_DEF,
  parameter logic [Y_W-1:0] GOAL_Y        = GOAL_Y_DEF,
  parameter logic [7:0]     INVULN_FRAMES = INVULN_FRAMES_DEF
) (
  input  logic           clk_in,
  input  logic           reset_in,
  input  logic           frame_tick,
  input  logic           start,
  input  logic [X_W-1:0] carL,
  input  logic [X_W-1:0] carR,
  input  logic [Y_W-1:0] carT,
  input  logic [Y_W-1:0] carB,
  input  logic [X_W-1:0] frogL,
  input  logic [X_W-1:0] frogR,
  input  logic [Y_W-1:0] frogT,
  input  logic [Y_W-1:0] frogB,
  output logic           pseudo,
  output logic [2:0]     level,
  output logic [1:0]     lives,
  output logic           hit_pulse,
  output logic           frog_respawn,
  output logic           game_over
);

  localparam logic [1:0] LIVES_RST = 2'(LIVES_INIT);

  state_t     state;
  logic [7:0] counter;
  logic       ov_prev;
  logic       ov;

  box_overlap u_box_overlap (
    .carL    (carL),
    .carR    (carR),
    .carT    (carT),
    .carB    (carB),
    .frogL   (frogL),
    .frogR   (frogR),
    .frogT   (frogT),
    .frogB   (frogB),
    .overlap (ov)
  );

  // A hit needs overlap on two consecutive frame ticks; this filters
  // single-frame grazes caused by car/frog update skew.
  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      state        <= PLAY;
      lives        <= LIVES_RST;
      level        <= 3'd0;
      pseudo       <= 1'b1;
      hit_pulse    <= 1'b0;
      frog_respawn <= 1'b0;
      game_over    <= 1'b0;
      counter      <= 8'd0;
      ov_prev      <= 1'b0;
    end else begin
      hit_pulse    <= 1'b0;
      frog_respawn <= 1'b0;
      case (state)
        PLAY: begin
          if (frame_tick) begin
            ov_prev <= ov;
            if (ov && ov_prev) begin
              hit_pulse <= 1'b1;
              if (lives > 2'd1) begin
                lives        <= lives - 2'd1;
                frog_respawn <= 1'b1;
                counter      <= INVULN_FRAMES;
                state        <= HIT;
              end else begin
                lives     <= 2'd0;
                game_over <= 1'b1;
                pseudo    <= 1'b0;
                state     <= OVER;
              end
            end else if (frogT <= GOAL_Y) begin
              if (level != LEVEL_MAX)
                level <= level + 3'd1;
              frog_respawn <= 1'b1;
              ov_prev      <= 1'b0;
            end
          end
        end
        HIT: begin
          if (frame_tick) begin
            ov_prev <= ov;
            if (counter <= 8'd1) begin
              counter <= 8'd0;
              ov_prev <= 1'b0;
              state   <= PLAY;
            end else begin
              counter <= counter - 8'd1;
            end
          end
        end
        OVER: begin
          if (start) begin
            lives        <= LIVES_RST;
            level        <= 3'd0;
            ov_prev      <= 1'b0;
            frog_respawn <= 1'b1;
            game_over    <= 1'b0;
            pseudo       <= 1'b1;
            state        <= PLAY;
          end
        end
        default: state <= PLAY;
      endcase
    end
  end

endmodule

// File: tb/tb_collision_monitor.sv
// Directed self-checking bench for collision_monitor with a short
// invulnerability window so several hits fit in a compact run.
module tb_collision_monitor;

  logic       clk_in = 1'b0;
  logic       reset_in;
  logic       frame_tick;
  logic       start;
  logic [9:0] carL, carR, frogL, frogR;
  logic [8:0] carT, carB, frogT, frogB;
  logic       pseudo;
  logic [2:0] level;
  logic [1:0] lives;
  logic       hit_pulse;
  logic       frog_respawn;
  logic       game_over;

  int testCount = 0;
  int failCount = 0;

  collision_monitor #(
    .LIVES_INIT    (3),
    .GOAL_Y        (9'd20),
    .INVULN_FRAMES (8'd4)
  ) dut (
    .clk_in       (clk_in),
    .reset_in     (reset_in),
    .frame_tick   (frame_tick),
    .start        (start),
    .carL         (carL),
    .carR         (carR),
    .carT         (carT),
    .carB         (carB),
    .frogL        (frogL),
    .frogR        (frogR),
    .frogT        (frogT),
    .frogB        (frogB),
    .pseudo       (pseudo),
    .level        (level),
    .lives        (lives),
    .hit_pulse    (hit_pulse),
    .frog_respawn (frog_respawn),
    .game_over    (game_over)
  );

  always #5 clk_in = ~clk_in;

  task automatic checkOutput(input string tag, input logic [7:0] observed,
                             input logic [7:0] expected);
    testCount++;
    assert (observed === expected)
    else begin
      failCount++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic setCar(input int l, input int r, input int t, input int b);
    carL = 10'(l); carR = 10'(r); carT = 9'(t); carB = 9'(b);
  endtask

  task automatic setFrog(input int l, input int r, input int t, input int b);
    frogL = 10'(l); frogR = 10'(r); frogT = 9'(t); frogB = 9'(b);
  endtask

  // Drive one clock cycle, then sample 1 time unit after the edge.
  task automatic applyStimulus(input logic tk, input logic st);
    frame_tick = tk;
    start      = st;
    @(posedge clk_in);
    #1;
    frame_tick = 1'b0;
    start      = 1'b0;
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_lives"},  lives, 8'd3);
    checkOutput({tag, "_level"},  level, 8'd0);
    checkOutput({tag, "_pseudo"}, pseudo, 8'd1);
    checkOutput({tag, "_hit"},    hit_pulse, 8'd0);
    checkOutput({tag, "_resp"},   frog_respawn, 8'd0);
    checkOutput({tag, "_over"},   game_over, 8'd0);
  endtask

  initial begin
    reset_in   = 1'b0;
    frame_tick = 1'b0;
    start      = 1'b0;
    setCar(300, 400, 300, 400);
    setFrog(200, 220, 120, 140);
    repeat (2) @(posedge clk_in);
    #1;
    checkResetValues("reset");
    reset_in = 1'b1;
    applyStimulus(1'b0, 1'b0);

    // Single-tick overlap then escape: no hit.
    setCar(20, 80, 110, 150);
    setFrog(40, 60, 120, 140);
    applyStimulus(1'b1, 1'b0);
    checkOutput("single_ov_hit", hit_pulse, 8'd0);
    setFrog(200, 220, 120, 140);
    applyStimulus(1'b1, 1'b0);
    checkOutput("escape_hit", hit_pulse, 8'd0);
    checkOutput("escape_lives", lives, 8'd3);

    // Edge touch frogR == carL is not overlap.
    setFrog(0, 20, 120, 140);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 1'b0);
      checkOutput("edge_hit", hit_pulse, 8'd0);
    end
    checkOutput("edge_lives", lives, 8'd3);

    // One goal reach.
    setCar(300, 400, 300, 400);
    setFrog(40, 60, 20, 40);
    applyStimulus(1'b1, 1'b0);
    checkOutput("goal1_level", level, 8'd1);
    checkOutput("goal1_resp", frog_respawn, 8'd1);
    applyStimulus(1'b0, 1'b0);
    checkOutput("goal1_resp_end", frog_respawn, 8'd0);
    checkOutput("notick_level", level, 8'd1);

    // Goal coincides with second overlap tick: hit wins.
    setCar(20, 80, 0, 150);
    setFrog(40, 60, 30, 50);
    applyStimulus(1'b1, 1'b0);
    checkOutput("gh_first_hit", hit_pulse, 8'd0);
    setFrog(40, 60, 10, 30);
    applyStimulus(1'b1, 1'b0);
    checkOutput("gh_hit", hit_pulse, 8'd1);
    checkOutput("gh_resp", frog_respawn, 8'd1);
    checkOutput("gh_lives", lives, 8'd2);
    checkOutput("gh_level", level, 8'd1);

    // Asynchronous reset mid-HIT.
    reset_in = 1'b0;
    #1;
    checkResetValues("midhit_reset");
    applyStimulus(1'b0, 1'b0);
    reset_in = 1'b1;
    applyStimulus(1'b0, 1'b0);
    checkOutput("post_reset_hit", hit_pulse, 8'd0);
    checkOutput("post_reset_resp", frog_respawn, 8'd0);
    setCar(20, 80, 110, 150);
    setFrog(40, 60, 120, 140);
    applyStimulus(1'b1, 1'b0);
    checkOutput("post_reset_ovprev", hit_pulse, 8'd0);
    checkOutput("post_reset_pseudo", pseudo, 8'd1);
    setFrog(200, 220, 120, 140);
    applyStimulus(1'b1, 1'b0);

    // Level saturation at 7 with one respawn per goal tick.
    setCar(300, 400, 300, 400);
    setFrog(40, 60, 20, 40);
    for (int i = 1; i <= 9; i++) begin
      applyStimulus(1'b1, 1'b0);
      checkOutput("sat_level", level, 8'((i > 7) ? 7 : i));
      checkOutput("sat_resp", frog_respawn, 8'd1);
      applyStimulus(1'b0, 1'b0);
      checkOutput("sat_resp_end", frog_respawn, 8'd0);
    end

    // Start outside OVER is ignored.
    applyStimulus(1'b0, 1'b1);
    checkOutput("start_play_resp", frog_respawn, 8'd0);
    checkOutput("start_play_level", level, 8'd7);

    // First hit: lives 3 -> 2.
    setCar(20, 80, 110, 150);
    setFrog(40, 60, 120, 140);
    applyStimulus(1'b1, 1'b0);
    checkOutput("h1_first", hit_pulse, 8'd0);
    applyStimulus(1'b1, 1'b0);
    checkOutput("h1_hit", hit_pulse, 8'd1);
    checkOutput("h1_resp", frog_respawn, 8'd1);
    checkOutput("h1_lives", lives, 8'd2);
    checkOutput("h1_pseudo", pseudo, 8'd1);
    applyStimulus(1'b0, 1'b0);
    checkOutput("h1_hit_end", hit_pulse, 8'd0);

    // Invulnerable for four ticks even while overlapping.
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 1'b0);
      checkOutput("inv_hit", hit_pulse, 8'd0);
      checkOutput("inv_lives", lives, 8'd2);
    end
    repeat (3) applyStimulus(1'b0, 1'b0);
    checkOutput("idle_lives", lives, 8'd2);

    // Second hit: ov_prev was cleared on leaving HIT.
    applyStimulus(1'b1, 1'b0);
    checkOutput("h2_first", hit_pulse, 8'd0);
    applyStimulus(1'b1, 1'b0);
    checkOutput("h2_hit", hit_pulse, 8'd1);
    checkOutput("h2_lives", lives, 8'd1);
    setFrog(200, 220, 120, 140);
    repeat (4) applyStimulus(1'b1, 1'b0);

    // Third hit ends the game.
    setFrog(40, 60, 120, 140);
    applyStimulus(1'b1, 1'b0);
    checkOutput("h3_first", hit_pulse, 8'd0);
    applyStimulus(1'b1, 1'b0);
    checkOutput("h3_hit", hit_pulse, 8'd1);
    checkOutput("h3_resp", frog_respawn, 8'd0);
    checkOutput("h3_lives", lives, 8'd0);
    checkOutput("h3_over", game_over, 8'd1);
    checkOutput("h3_pseudo", pseudo, 8'd0);

    // OVER ignores frame inputs.
    setFrog(40, 60, 10, 30);
    repeat (3) applyStimulus(1'b1, 1'b0);
    checkOutput("over_lives", lives, 8'd0);
    checkOutput("over_level", level, 8'd7);
    checkOutput("over_hit", hit_pulse, 8'd0);
    checkOutput("over_flag", game_over, 8'd1);

    // Restart.
    applyStimulus(1'b0, 1'b1);
    checkOutput("restart_resp", frog_respawn, 8'd1);
    checkOutput("restart_lives", lives, 8'd3);
    checkOutput("restart_level", level, 8'd0);
    checkOutput("restart_over", game_over, 8'd0);
    checkOutput("restart_pseudo", pseudo, 8'd1);
    applyStimulus(1'b0, 1'b0);
    checkOutput("restart_resp_end", frog_respawn, 8'd0);
    setFrog(40, 60, 120, 140);
    applyStimulus(1'b1, 1'b0);
    checkOutput("restart_ovprev", hit_pulse, 8'd0);
    checkOutput("restart_lives_kept", lives, 8'd3);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
